mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 149 ++++++++++++++
 tb/tb_mc_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM for a small MIPS subset (IF/ID/EXE/MEM/WB).
// Outputs decode the registered state plus the held instruction; rst blanks them all.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic [2:0] alu_op,
  output logic       alu_addi,
  output logic       alu_slt,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t state_q;
  logic   ovf_q;
  logic   is_r, is_addu, is_subu, is_or, is_slt;
  logic   is_addi, is_ori, is_lw, is_sw, is_beq, is_j, is_supported;

  always_comb begin
    is_r         = (op == OP_RTYPE);
    is_addu      = is_r && (funct == FN_ADDU);
    is_subu      = is_r && (funct == FN_SUBU);
    is_or        = is_r && (funct == FN_OR);
    is_slt       = is_r && (funct == FN_SLT);
    is_addi      = (op == OP_ADDI);
    is_ori       = (op == OP_ORI);
    is_lw        = (op == OP_LW);
    is_sw        = (op == OP_SW);
    is_beq       = (op == OP_BEQ);
    is_j         = (op == OP_J);
    is_supported = is_addu | is_subu | is_or | is_slt | is_addi |
                   is_ori | is_lw | is_sw | is_beq;
  end

  // ovf_q is only ever nonzero in WB, so defaulting it to 0 doubles as the IF-entry clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IF;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= ST_IF;
      ovf_q   <= 1'b0;
      case (state_q)
        ST_IF:  state_q <= ST_ID;
        ST_ID:  if (is_supported) state_q <= ST_EXE;
        ST_EXE: begin
          if (is_lw || is_sw) begin
            state_q <= ST_MEM;
          end else if (is_supported && !is_beq) begin
            state_q <= ST_WB;
            ovf_q   <= overflow;
          end
        end
        ST_MEM: if (is_lw) state_q <= ST_WB;
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_op     = 3'd0;
    alu_addi   = 1'b0;
    alu_slt    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_src     = 2'd0;
    state      = 3'd0;
    illegal    = 1'b0;
    if (!rst) begin
      state = state_q;
      case (state_q)
        ST_IF: begin
          pc_wr     = 1'b1;
          ir_wr     = 1'b1;
          alu_src_b = 2'd1;
        end
        ST_ID: begin
          alu_src_b = 2'd2;
          if (is_j) begin
            pc_wr  = 1'b1;
            pc_src = 2'd2;
          end else if (!is_supported) begin
            illegal = 1'b1;
          end
        end
        ST_EXE: begin
          alu_src_a = 1'b1;
          alu_slt   = is_slt;
          alu_addi  = is_addi;
          if (is_subu || is_slt || is_beq) alu_op = 3'd1;
          else if (is_or || is_ori)        alu_op = 3'd2;
          if (is_addi || is_lw || is_sw) alu_src_b = 2'd2;
          else if (is_ori)               alu_src_b = 2'd3;
          // beq commits the branch in this same cycle from the live zero flag
          if (is_beq) begin
            pc_src = 2'd1;
            pc_wr  = zero;
          end
        end
        ST_MEM: mem_wr = is_sw;
        ST_WB: begin
          reg_wr     = !(is_addi && ovf_q);
          mem_to_reg = is_lw;
          reg_dst    = is_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: driver pushes per-cycle expectations from an
// instruction-level model into a scoreboard; a negedge monitor pops and compares.
module tb_mc_ctrl;

  bit         clk = 1'b1;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, overflow;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, mem_to_reg, reg_dst;
  logic [2:0] alu_op;
  logic       alu_addi, alu_slt, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] state;
  logic       illegal;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_wr(mem_wr),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_op(alu_op),
    .alu_addi(alu_addi), .alu_slt(alu_slt), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_wr, ir_wr, reg_wr, mem_wr, mem_to_reg, reg_dst;
    logic [2:0] alu_op;
    logic       alu_addi, alu_slt, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] state;
    logic       illegal;
  } vec_t;

  vec_t  exp_q[$];
  string tag_q[$];
  vec_t  mdl[8];
  int    n_compared = 0;
  int    n_mismatched = 0;

  task automatic checkOutput(input vec_t e, input string t);
    vec_t a;
    a = {pc_wr, ir_wr, reg_wr, mem_wr, mem_to_reg, reg_dst, alu_op, alu_addi,
         alu_slt, alu_src_a, alu_src_b, pc_src, state, illegal};
    n_compared++;
    if (a !== e) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %05h (state %0d) required %05h (state %0d) at %0t",
               t, a, a.state, e, e.state, $time);
    end
  endtask

  // Instruction-level reference: the cycle-by-cycle output vectors an instruction should produce
  task automatic build_model(input logic [5:0] o, input logic [5:0] f,
                             input logic z, input logic ov, output int n);
    vec_t v;
    bit   r_ok;
    r_ok = (o == 6'h00) && (f inside {6'h21, 6'h23, 6'h25, 6'h2A});
    n = 0;
    v = '0; v.pc_wr = 1; v.ir_wr = 1; v.alu_src_b = 2'd1;
    mdl[n] = v; n++;
    v = '0; v.state = 3'd1; v.alu_src_b = 2'd2;
    if (o == 6'h02) begin
      v.pc_wr = 1; v.pc_src = 2'd2;
      mdl[n] = v; n++;
      return;
    end
    if (!(r_ok || (o inside {6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04}))) begin
      v.illegal = 1;
      mdl[n] = v; n++;
      return;
    end
    mdl[n] = v; n++;
    v = '0; v.state = 3'd2; v.alu_src_a = 1;
    case (o)
      6'h00: begin
        case (f)
          6'h21: v.alu_op = 3'd0;
          6'h23: v.alu_op = 3'd1;
          6'h25: v.alu_op = 3'd2;
          default: begin v.alu_op = 3'd1; v.alu_slt = 1; end
        endcase
        mdl[n] = v; n++;
        v = '0; v.state = 3'd4; v.reg_wr = 1; v.reg_dst = 1;
        mdl[n] = v; n++;
      end
      6'h08: begin
        v.alu_addi = 1; v.alu_src_b = 2'd2;
        mdl[n] = v; n++;
        v = '0; v.state = 3'd4; v.reg_wr = !ov;
        mdl[n] = v; n++;
      end
      6'h0D: begin
        v.alu_op = 3'd2; v.alu_src_b = 2'd3;
        mdl[n] = v; n++;
        v = '0; v.state = 3'd4; v.reg_wr = 1;
        mdl[n] = v; n++;
      end
      6'h04: begin
        v.alu_op = 3'd1; v.pc_src = 2'd1; v.pc_wr = z;
        mdl[n] = v; n++;
      end
      default: begin
        v.alu_src_b = 2'd2;
        mdl[n] = v; n++;
        v = '0; v.state = 3'd3; v.mem_wr = (o == 6'h2B);
        mdl[n] = v; n++;
        if (o == 6'h23) begin
          v = '0; v.state = 3'd4; v.reg_wr = 1; v.mem_to_reg = 1;
          mdl[n] = v; n++;
        end
      end
    endcase
  endtask

  // Called just after a rising edge; abort_at>0 pulses rst during that cycle index
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input logic ov, input int abort_at, input int rst_len,
                               input string name);
    int n, k;
    build_model(o, f, z, ov, n);
    op = o; funct = f; zero = z; overflow = ov;
    k = (abort_at > 0 && abort_at < n) ? abort_at : n;
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(mdl[i]);
      tag_q.push_back($sformatf("%s c%0d", name, i));
    end
    repeat (k) @(posedge clk);
    #1;
    if (k < n) begin
      rst = 1;
      for (int i = 0; i < rst_len; i++) begin
        exp_q.push_back('0);
        tag_q.push_back($sformatf("%s rst%0d", name, i));
      end
      repeat (rst_len) @(posedge clk);
      #1;
      rst = 0;
    end
  endtask

  initial begin
    vec_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checkOutput(e, t);
      end
    end
  end

  initial begin
    logic [5:0] op_tab[8] = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h08, 6'h0D, 6'h23, 6'h2B};
    logic [5:0] fn_tab[4] = '{6'h21, 6'h23, 6'h25, 6'h2A};
    logic [5:0] o, f;
    int sel, abort_at;

    rst = 1; op = 6'h00; funct = 6'h00; zero = 0; overflow = 0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      tag_q.push_back($sformatf("reset%0d", i));
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    applyStimulus(6'h23, 6'h15, 0, 1, 0, 1, "lw");
    applyStimulus(6'h2B, 6'h00, 1, 0, 0, 1, "sw");
    applyStimulus(6'h04, 6'h00, 1, 0, 0, 1, "beq_taken");
    applyStimulus(6'h04, 6'h00, 0, 1, 0, 1, "beq_not_taken");
    applyStimulus(6'h08, 6'h00, 0, 1, 0, 1, "addi_ovf");
    applyStimulus(6'h08, 6'h00, 0, 0, 0, 1, "addi_ok");
    applyStimulus(6'h3F, 6'h21, 0, 0, 0, 1, "illegal_op");
    applyStimulus(6'h00, 6'h00, 0, 0, 0, 1, "illegal_funct");
    applyStimulus(6'h2B, 6'h00, 0, 0, 3, 1, "sw_rst_in_mem");
    applyStimulus(6'h00, 6'h21, 1, 1, 0, 1, "addu");
    applyStimulus(6'h00, 6'h23, 0, 1, 0, 1, "subu");
    applyStimulus(6'h00, 6'h25, 1, 0, 0, 1, "or");
    applyStimulus(6'h00, 6'h2A, 0, 1, 0, 1, "slt");
    applyStimulus(6'h0D, 6'h00, 1, 1, 0, 1, "ori");
    applyStimulus(6'h02, 6'h00, 1, 1, 0, 1, "j");
    applyStimulus(6'h23, 6'h00, 0, 0, 4, 2, "lw_rst_in_wb");

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      o = (sel < 8) ? op_tab[sel] : 6'($urandom);
      f = ($urandom_range(0, 4) < 4) ? fn_tab[$urandom_range(0, 3)] : 6'($urandom);
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      applyStimulus(o, f, 1'($urandom), 1'($urandom), abort_at, $urandom_range(1, 2),
                    $sformatf("rand%0d op%02h f%02h", i, o, f));
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
